// File: rtl/filter_buf_pkg.sv
// Shared types and helpers for the double-buffered filter coefficient buffer.
package filter_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Filter length in words once the beat starting at word wr_ptr has been written.
  function automatic int unsigned commit_len(int unsigned wr_ptr, int unsigned lanes);
    return wr_ptr + lanes;
  endfunction

endpackage

// File: rtl/filter_bank.sv
// One coefficient bank: LANES-wide writes at a word offset, a committed length,
// and a parallel window whose words at or beyond that length read as zero.
module filter_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  parameter int LEN_W  = $clog2(DEPTH+1),
  parameter int OFF_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [OFF_W-1:0]          wr_off,
  input  logic [LANES*DATA_W-1:0]   wr_data,
  input  logic                      commit,
  input  logic [LEN_W-1:0]          commit_len,
  output logic [LEN_W-1:0]          len,
  output logic [DEPTH*DATA_W-1:0]   window
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared; stale words are hidden by the length mask.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        mem[wr_off + OFF_W'(l)] <= wr_data[l*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len <= '0;
    end else if (commit) begin
      len <= commit_len;
    end
  end

  always_comb begin
    window = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (LEN_W'(k) < len) begin
        window[k*DATA_W +: DATA_W] = mem[k];
      end
    end
  end

endmodule

// File: rtl/filter_window_buffer.sv
// Ping-pong filter buffer: beats fill bank f while the engine reads bank r.
//   bank state   | meaning
//   BANK_EMPTY   | free, no words written since last release/reset
//   BANK_FILLING | receiving beats of a filter not yet committed
//   BANK_FULL    | committed filter, presented when r points here
module filter_window_buffer
  import filter_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  parameter int LEN_W  = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [LANES*DATA_W-1:0]   wr_data,
  input  logic                      wr_last,
  output logic                      rd_valid,
  output logic [DEPTH*DATA_W-1:0]   rd_data,
  output logic [LEN_W-1:0]          rd_len,
  input  logic                      rd_release,
  output logic                      err_overflow
);

  localparam int OFF_W    = $clog2(DEPTH);
  localparam int LAST_OFF = DEPTH - LANES;

  bank_state_t             state [2];
  logic                    f;
  logic                    r;
  logic [OFF_W-1:0]        wr_ptr;
  logic                    accept;
  logic                    at_last;
  logic                    commit;
  logic                    release_ok;
  logic [LEN_W-1:0]        new_len;
  logic [LEN_W-1:0]        bank_len [2];
  logic [DEPTH*DATA_W-1:0] bank_win [2];

  assign wr_ready   = !rst && (state[f] != BANK_FULL);
  assign rd_valid   = (state[r] == BANK_FULL);
  assign accept     = wr_valid && wr_ready;
  assign at_last    = (wr_ptr == OFF_W'(LAST_OFF));
  assign commit     = accept && (wr_last || at_last);
  assign release_ok = rd_release && rd_valid;
  assign new_len    = LEN_W'(commit_len(32'(wr_ptr), LANES));

  assign rd_len  = rd_valid ? bank_len[r] : '0;
  assign rd_data = rd_valid ? bank_win[r] : '0;

  for (genvar g = 0; g < 2; g++) begin : gen_bank
    filter_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LANES  (LANES),
      .LEN_W  (LEN_W),
      .OFF_W  (OFF_W)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (accept && (f == 1'(g))),
      .wr_off     (wr_ptr),
      .wr_data    (wr_data),
      .commit     (commit && (f == 1'(g))),
      .commit_len (new_len),
      .len        (bank_len[g]),
      .window     (bank_win[g])
    );
  end

  // Commit and release never hit the same bank: commit needs state[f] != FULL,
  // release needs state[r] == FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state[0]     <= BANK_EMPTY;
      state[1]     <= BANK_EMPTY;
      f            <= 1'b0;
      r            <= 1'b0;
      wr_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= accept && at_last && !wr_last;
      if (accept) begin
        if (commit) begin
          state[f] <= BANK_FULL;
          wr_ptr   <= '0;
          f        <= ~f;
        end else begin
          state[f] <= BANK_FILLING;
          wr_ptr   <= wr_ptr + OFF_W'(LANES);
        end
      end
      if (release_ok) begin
        state[r] <= BANK_EMPTY;
        r        <= ~r;
      end
    end
  end

endmodule
